// File: rtl/seg_defs_pkg.sv
// Shared definitions for the 7-segment scan driver: digit count, anode idle
// pattern, FSM state encoding and the phase counter width helper.
package seg_defs;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W = 2;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Counter must hold N-1 for the longer phase; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/seg_phase_timer.sv
// Phase length timer: counts cycles within a BLANK or DRIVE phase and flags
// the last cycle so the FSM can advance; load restarts the count at zero.
module seg_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // len is the last index of the phase (N-1), so done lands on its final cycle.
  assign done = (count_reg == len);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with blanking dead
// time and a frame-atomic message/enable double buffer.
module seg_scan_driver
  import seg_defs::*;
#(
  parameter int DRIVE_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] msg_in,
  input  logic        msg_wr,
  input  logic [3:0]  en_in,
  output logic [3:0]  char,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CNT_W = cnt_width(DRIVE_CYCLES, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t               state_reg, state_next;
  logic [DIGIT_W-1:0]   digit_reg, digit_next;
  logic                 phase_done;
  logic [CNT_W-1:0]     phase_len;
  logic                 boundary;

  logic [15:0]          pend_msg_reg, act_msg_reg;
  logic [3:0]           pend_en_reg, act_en_reg;
  logic [3:0]           char_reg, an_reg;
  logic                 frame_tick_reg;

  logic [3:0]           nib [NUM_DIGITS];
  logic [3:0]           an_drive;

  assign phase_len = (state_reg == ST_DRIVE) ? DRIVE_LAST : BLANK_LAST;

  seg_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (phase_done),
    .len     (phase_len),
    .done    (phase_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_BLANK;
      digit_reg <= '0;
    end else begin
      state_reg <= state_next;
      digit_reg <= digit_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    digit_next = digit_reg;
    if (phase_done) begin
      if (state_reg == ST_BLANK) begin
        state_next = ST_DRIVE;
      end else begin
        state_next = ST_BLANK;
        digit_next = digit_reg + DIGIT_W'(1);
      end
    end
  end

  // The edge leaving DRIVE of the last digit starts a new frame.
  assign boundary = phase_done && (state_reg == ST_DRIVE) &&
                    (digit_reg == DIGIT_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_msg_reg   <= 16'h0000;
      pend_en_reg    <= AN_OFF;
      act_msg_reg    <= 16'h0000;
      act_en_reg     <= AN_OFF;
      frame_tick_reg <= 1'b0;
    end else begin
      if (msg_wr) begin
        pend_msg_reg <= msg_in;
        pend_en_reg  <= en_in;
      end
      // A write landing on the boundary edge bypasses pending straight to active.
      if (boundary) begin
        act_msg_reg <= msg_wr ? msg_in : pend_msg_reg;
        act_en_reg  <= msg_wr ? en_in  : pend_en_reg;
      end
      frame_tick_reg <= boundary;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi]      = act_msg_reg[4*gi +: 4];
    assign an_drive[gi] = ~((state_reg == ST_DRIVE) &&
                            (digit_reg == DIGIT_W'(gi)) &&
                            act_en_reg[gi]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      char_reg <= 4'h0;
      an_reg   <= AN_OFF;
    end else begin
      char_reg <= nib[digit_reg];
      an_reg   <= an_drive;
    end
  end

  assign char       = char_reg;
  assign an         = an_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random writes/resets,
// each cycle compared against a frame-position reference model.
module tb_seg_scan_driver;

  localparam int DRV   = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = DRV + BLK;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        msg_wr = 1'b0;
  logic [15:0] msg_in = 16'h0000;
  logic [3:0]  en_in = 4'hF;
  logic [3:0]  char, an;
  logic        frame_tick;

  seg_scan_driver #(
    .DRIVE_CYCLES (DRV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .msg_in     (msg_in),
    .msg_wr     (msg_wr),
    .en_in      (en_in),
    .char       (char),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: t = cycles since the last reset edge; active buffer swaps every FRAME.
  int          t = 0;
  logic [15:0] pend_msg = 16'h0000, act_msg = 16'h0000;
  logic [3:0]  pend_en = 4'hF, act_en = 4'hF;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
    end
  endtask

  task automatic step(input logic rst_n_v, input logic wr, input logic [15:0] msg, input logic [3:0] en);
    logic [15:0] prev_msg;
    logic [3:0]  prev_en;
    logic [3:0]  exp_an, exp_char;
    logic        exp_tick;
    int          p, d;
    @(negedge clk);
    reset_n = rst_n_v;
    msg_wr  = wr;
    msg_in  = msg;
    en_in   = en;
    prev_msg = act_msg;
    prev_en  = act_en;
    @(posedge clk);
    if (!rst_n_v) begin
      t = 0;
      pend_msg = 16'h0000; act_msg = 16'h0000;
      pend_en  = 4'hF;     act_en  = 4'hF;
    end else begin
      t++;
      if (wr) begin
        pend_msg = msg;
        pend_en  = en;
      end
      if (t % FRAME == 0) begin
        act_msg = pend_msg;
        act_en  = pend_en;
      end
    end
    if (t == 0) begin
      exp_an = 4'hF; exp_char = 4'h0; exp_tick = 1'b0;
    end else begin
      // Outputs show the frame position of the previous cycle.
      p = (t - 1) % FRAME;
      d = p / SLOT;
      exp_char = prev_msg[4*d +: 4];
      exp_an   = ((p % SLOT) >= BLK && prev_en[d]) ? ~(4'b0001 << d) : 4'hF;
      exp_tick = (t % FRAME == 0);
    end
    #1;
    check("an", an, exp_an);
    check("char", char, exp_char);
    check("frame_tick", {3'b000, frame_tick}, {3'b000, exp_tick});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 4'hF);
  endtask

  // Advance until the next edge is the one that lands on position pos.
  task automatic goto_pos(input int pos);
    for (int i = 0; i < FRAME && ((t + 1) % FRAME) != pos; i++) idle(1);
  endtask

  initial begin
    // 1: reset then two idle frames
    step(1'b0, 1'b0, 16'h0000, 4'hF);
    step(1'b0, 1'b0, 16'h0000, 4'hF);
    idle(2 * FRAME);

    // 2: mid-frame write
    goto_pos(10);
    step(1'b1, 1'b1, 16'h1A3F, 4'hF);
    idle(2 * FRAME);

    // 3: two writes in one frame, last wins
    goto_pos(5);
    step(1'b1, 1'b1, 16'h1111, 4'hF);
    goto_pos(15);
    step(1'b1, 1'b1, 16'h2222, 4'hF);
    idle(2 * FRAME);

    // 4: write exactly on the frame boundary edge
    goto_pos(0);
    step(1'b1, 1'b1, 16'hBEEF, 4'hF);
    idle(FRAME + 2);

    // 5: partial enables
    goto_pos(7);
    step(1'b1, 1'b1, 16'h8888, 4'b0101);
    idle(2 * FRAME);

    // 6: one-cycle reset during DRIVE of digit 2
    goto_pos(15);
    step(1'b0, 1'b0, 16'h0000, 4'hF);
    idle(FRAME + 4);

    // 7: random writes and occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0),
           16'($urandom), 4'($urandom));
    end
    idle(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
